// File: rtl/decoder_mul_pipe_q.sv
// Pipelined signed multiplier with valid/ready flow control and round-half-up requantisation.
// Optional saturation with overflow flag is enabled by defining DECODER_MUL_PIPE_SAT_EN.
module decoder_mul_pipe_q #(
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 9,
  parameter int unsigned dout_WIDTH = 16,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned W  = din0_WIDTH + din1_WIDTH;
  // Wide enough for the rounding add and for range compares against the dout limits.
  localparam int unsigned XW = (((W + 1) > dout_WIDTH) ? (W + 1) : dout_WIDTH) + 1;

  localparam logic signed [XW-1:0] RND =
    (SHIFT == 0) ? '0 : (XW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

  logic                  stall;
  logic [NUM_STAGE-1:0]  vld_q, vld_d;
  logic [W-1:0]          a_ext, b_ext;
  logic signed [W-1:0]   prod;
  logic signed [W-1:0]   last_p;
  logic signed [XW-1:0]  rnd_sum, r_full;
  logic [dout_WIDTH-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;

  // Flat global stall: the whole pipe freezes while the output is blocked.
  assign stall     = vld_q[NUM_STAGE-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  assign a_ext = {{(W - din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
  assign b_ext = {{(W - din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
  assign prod  = $signed(a_ext) * $signed(b_ext);

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int i = 1; i < NUM_STAGE; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
    end
  end

  if (NUM_STAGE == 1) begin : g_single
    assign last_p = prod;
  end else begin : g_pipe
    logic signed [W-1:0] p_q [NUM_STAGE-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) begin
          p_q[i] <= '0;
        end
      end else if (!stall) begin
        p_q[0] <= prod;
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          p_q[i] <= p_q[i-1];
        end
      end
    end

    assign last_p = p_q[NUM_STAGE-2];
  end

  assign rnd_sum = {{(XW - W){last_p[W-1]}}, last_p} + RND;
  assign r_full  = rnd_sum >>> SHIFT;

`ifdef DECODER_MUL_PIPE_SAT_EN
  localparam logic signed [XW-1:0] MAXV =
    {{(XW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {{(XW - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};

  always_comb begin
    dout_d = r_full[dout_WIDTH-1:0];
    ovf_d  = 1'b0;
    if (r_full > MAXV) begin
      dout_d = MAXV[dout_WIDTH-1:0];
      ovf_d  = 1'b1;
    end else if (r_full < MINV) begin
      dout_d = MINV[dout_WIDTH-1:0];
      ovf_d  = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^r_full[XW-1:dout_WIDTH];

  always_comb begin
    dout_d = r_full[dout_WIDTH-1:0];
    ovf_d  = 1'b0;
  end
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!stall) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_decoder_mul_pipe_q.sv
// Scoreboard bench for decoder_mul_pipe_q: directed cases, backpressure, throughput and reset.
module tb_decoder_mul_pipe_q;

  localparam int unsigned A_W = 16;
  localparam int unsigned B_W = 9;
  localparam int unsigned D_W = 16;
  localparam int unsigned NS  = 3;
  localparam int unsigned SH  = 8;

  typedef struct packed {
    logic [D_W-1:0] d;
    logic           o;
  } exp_t;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [A_W-1:0] din0 = '0;
  logic [B_W-1:0] din1 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [D_W-1:0] dout;
  logic           ovf;

  exp_t sb[$];
  int   fire_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  decoder_mul_pipe_q #(
    .din0_WIDTH(A_W),
    .din1_WIDTH(B_W),
    .dout_WIDTH(D_W),
    .NUM_STAGE (NS),
    .SHIFT     (SH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .ovf      (ovf)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input longint d, input logic o);
    exp_t e;
    e.d = D_W'(d);
    e.o = o;
    return e;
  endfunction

  // Reference: exact product, floor((P + 2^(SH-1)) / 2^SH), then clamp or wrap.
  function automatic exp_t model(input longint a, input longint b);
    longint p, r, maxv, minv;
    p = a * b;
    if (SH > 0) r = (p + (longint'(1) <<< (SH - 1))) >>> SH;
    else        r = p;
    maxv = (longint'(1) <<< (D_W - 1)) - 1;
    minv = -maxv - 1;
`ifdef DECODER_MUL_PIPE_SAT_EN
    if (r > maxv)      return mk(maxv, 1'b1);
    else if (r < minv) return mk(minv, 1'b1);
    else               return mk(r, 1'b0);
`else
    return mk(r, 1'b0);
`endif
  endfunction

  // Presents one operand pair until accepted; expectation enters the scoreboard on accept.
  task automatic send(input longint a, input longint b, input exp_t e, output int acc);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    acc = -1;
    din0     = A_W'(a);
    din1     = B_W'(b);
    in_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge ap_clk);
      got = in_ready;
      if (got) begin
        sb.push_back(e);
        acc = cyc;
      end
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("accept", got, 1);
  endtask

  task automatic send_rand();
    logic signed [A_W-1:0] ra;
    logic signed [B_W-1:0] rb;
    int acc;
    ra = A_W'($urandom);
    rb = B_W'($urandom);
    send(longint'(ra), longint'(rb), model(longint'(ra), longint'(rb)), acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic bp_stream();
    for (int i = 0; i < 6; i++) send_rand();
    in_valid = 1'b0;
  endtask

  task automatic bp_ctl();
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!out_valid && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    chk("bp_first_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_low", in_ready, 0);
      @(negedge ap_clk);
    end
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
  endtask

  // Output monitor: pops on every output transfer and checks stall stability.
  initial begin
    logic           pstall;
    logic [D_W-1:0] pdout;
    exp_t           e;
    pstall = 1'b0;
    pdout  = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          chk("stall_hold_valid", out_valid, 1);
          chk("stall_hold_dout", dout, pdout);
        end
        if (out_valid && out_ready) begin
          fire_cyc.push_back(cyc);
          chk("output_expected", longint'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dout", $signed(dout), $signed(e.d));
            chk("ovf", ovf, e.o);
          end
        end
        pstall = out_valid && !out_ready;
        pdout  = dout;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    ap_rst_n = 1'b1;

    // Latency and a near-full-scale product
    out_ready = 1'b1;
    fire_cyc.delete();
    send(32767, 255, mk(32639, 1'b0), acc);
    in_valid = 1'b0;
    drain();
    chk("latency", (fire_cyc.size() > 0) ? fire_cyc[0] - acc : -1, NS);

    // Rounding ties go toward +inf
    send(1, 128, mk(1, 1'b0), acc);
    send(-1, 128, mk(0, 1'b0), acc);
    send(3, -128, mk(-1, 1'b0), acc);
    // Out-of-range result
`ifdef DECODER_MUL_PIPE_SAT_EN
    send(-32768, -256, mk(32767, 1'b1), acc);
`else
    send(-32768, -256, mk(-32768, 1'b0), acc);
`endif
    in_valid = 1'b0;
    drain();

    // Backpressure
    out_ready = 1'b0;
    fire_cyc.delete();
    fork
      bp_stream();
      bp_ctl();
    join
    drain();
    chk("bp_count", fire_cyc.size(), 6);

    // Throughput
    out_ready = 1'b1;
    fire_cyc.delete();
    for (int i = 0; i < 100; i++) send_rand();
    in_valid = 1'b0;
    drain();
    chk("tput_count", fire_cyc.size(), 100);
    chk("tput_span", (fire_cyc.size() == 100) ? fire_cyc[99] - fire_cyc[0] : -1, 99);

    // Reset with three results in flight
    out_ready = 1'b0;
    send(1000, 100, model(1000, 100), acc);
    send(-2000, 77, model(-2000, 77), acc);
    send(1234, -99, model(1234, -99), acc);
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_dout", dout, 16'd391);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_dout", dout, 0);
    chk("async_reset_ovf", ovf, 0);
    sb.delete();
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    fire_cyc.delete();
    repeat (10) @(posedge ap_clk);
    #1;
    chk("no_stale_results", fire_cyc.size(), 0);

    // Recovery after reset
    for (int i = 0; i < 8; i++) send_rand();
    in_valid = 1'b0;
    drain();
    chk("recovery_count", fire_cyc.size(), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
